// File: rtl/regfile_seq_fsm_pkg.sv
// Shared encodings for the BRM datapath sequencer: FSM states, instruction
// opcode/op fields and writeback source selects.
package regfile_seq_fsm_pkg;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_GET_A     = 3'd2,
    S_GET_B     = 3'd3,
    S_ALU       = 3'd4,
    S_WRITE_REG = 3'd5,
    S_WRITE_IMM = 3'd6
  } state_e;

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOVIMM  = 2'b10;
  localparam logic [1:0] OP_MOVREG  = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_IMM   = 2'b10;

endpackage

// File: rtl/regfile_seq_fsm_instr_dec.sv
// Combinational decode of the captured instruction into instruction class
// flags and register index fields.
module regfile_seq_fsm_instr_dec
  import regfile_seq_fsm_pkg::*;
(
  input  logic [15:0] ir,
  output logic        is_movimm,
  output logic        is_movreg,
  output logic        is_alu,
  output logic        is_cmp,
  output logic        is_illegal,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm
);

  logic [2:0] opcode;
  logic [1:0] op;
  logic       unused_sh;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  // shift amount is consumed by the datapath shifter, not by the sequencer
  assign unused_sh = ^ir[4:3];

  assign is_movimm  = (opcode == OPC_MOV) && (op == OP_MOVIMM);
  assign is_movreg  = (opcode == OPC_MOV) && (op == OP_MOVREG);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign is_illegal = !(is_movimm || is_movreg || is_alu);

endmodule

// File: rtl/regfile_seq_fsm.sv
// Sequencer for the BRM datapath: accepts one instruction per start pulse and
// steps the regfile/pipeline/ALU/status strobes until it returns to WAIT.
//
// state       | meaning
// ------------+--------------------------------------------------
// S_WAIT      | idle, w = 1, captures instr into IR when s = 1
// S_DECODE    | classify IR; illegal encodings pulse illegal here
// S_GET_A     | read Rn into A
// S_GET_B     | read Rm into B
// S_ALU       | load C and/or status (asel = 1 for MOV Rd,Rm)
// S_WRITE_REG | write C to Rd
// S_WRITE_IMM | write sign-extended imm8 to Rn
module regfile_seq_fsm
  import regfile_seq_fsm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic       is_movimm, is_movreg, is_alu, is_cmp, is_illegal;
  logic [2:0] rn, rd, rm;

  regfile_seq_fsm_instr_dec u_dec (
    .ir         (ir_q),
    .is_movimm  (is_movimm),
    .is_movreg  (is_movreg),
    .is_alu     (is_alu),
    .is_cmp     (is_cmp),
    .is_illegal (is_illegal),
    .rn         (rn),
    .rd         (rd),
    .rm         (rm)
  );

  assign ir_d = (state_q == S_WAIT && s) ? instr : ir_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = S_WAIT;
    case (state_q)
      S_WAIT:      state_d = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        if (is_movimm)      state_d = S_WRITE_IMM;
        else if (is_movreg) state_d = S_GET_B;
        else if (is_alu)    state_d = S_GET_A;
        else                state_d = S_WAIT;
      end
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
      S_WRITE_IMM: state_d = S_WAIT;
      default:     state_d = S_WAIT;
    endcase
  end

  always_comb begin
    w        = 1'b0;
    readnum  = 3'd0;
    writenum = 3'd0;
    write    = 1'b0;
    vsel     = VSEL_C;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      S_WAIT:   w = 1'b1;
      S_DECODE: illegal = is_illegal;
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
      end
      S_ALU: begin
        asel  = is_movreg;
        loads = 1'b1;
        loadc = !is_cmp;
      end
      S_WRITE_REG: begin
        write    = 1'b1;
        writenum = rd;
        vsel     = VSEL_C;
      end
      S_WRITE_IMM: begin
        write    = 1'b1;
        writenum = rn;
        vsel     = VSEL_IMM;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_seq_fsm.sv
// Directed bench for regfile_seq_fsm: hand-computed output vectors per cycle.
module tb_regfile_seq_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s;
  logic [15:0] instr;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel, illegal;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel;

  int n_cmp = 0;
  int n_err = 0;

  regfile_seq_fsm dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (s),
    .instr    (instr),
    .w        (w),
    .readnum  (readnum),
    .writenum (writenum),
    .write    (write),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .asel     (asel),
    .bsel     (bsel),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // {w, write, writenum, vsel, readnum, loada, loadb, loadc, loads, asel, bsel, illegal}
  function automatic logic [16:0] ex(input logic w_e, input logic wr_e,
                                     input logic [2:0] wn_e, input logic [1:0] vs_e,
                                     input logic [2:0] rn_e, input logic la_e,
                                     input logic lb_e, input logic lc_e,
                                     input logic ls_e, input logic as_e,
                                     input logic il_e);
    return {w_e, wr_e, wn_e, vs_e, rn_e, la_e, lb_e, lc_e, ls_e, as_e, 1'b0, il_e};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp_v);
    logic [16:0] obs;
    obs = {w, write, writenum, vsel, readnum, loada, loadb, loadc, loads, asel, bsel, illegal};
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [16:0] IDLE, NONE;

  initial begin
    IDLE = ex(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    NONE = ex(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    s     = 1'b0;
    instr = 16'h0000;

    #2 rst_n = 1'b0;
    #1 chk("reset_async", IDLE);
    step();
    rst_n = 1'b1;
    step(); chk("post_reset_wait0", IDLE);
    step(); chk("post_reset_wait1", IDLE);

    // MOV R3,#42
    instr = 16'hD32A; s = 1'b1;
    step(); s = 1'b0;
    chk("movi_decode", NONE);
    step(); chk("movi_write", ex(0, 1, 3, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    step(); chk("movi_done", IDLE);

    // ADD R2,R1,R0
    instr = 16'hA140; s = 1'b1;
    step(); s = 1'b0;
    chk("add_decode", NONE);
    step(); chk("add_get_a", ex(0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0));
    step(); chk("add_get_b", ex(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    step(); chk("add_alu",   ex(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 0, 0));
    step(); chk("add_write", ex(0, 1, 2, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(); chk("add_done", IDLE);

    // CMP R5,R6
    instr = 16'hAD06; s = 1'b1;
    step(); s = 1'b0;
    chk("cmp_decode", NONE);
    step(); chk("cmp_get_a", ex(0, 0, 0, 2'b00, 5, 1, 0, 0, 0, 0, 0));
    step(); chk("cmp_get_b", ex(0, 0, 0, 2'b00, 6, 0, 1, 0, 0, 0, 0));
    step(); chk("cmp_alu",   ex(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, 0));
    step(); chk("cmp_done", IDLE);

    // MOV R7,R4 with instr scrambled after acceptance
    instr = 16'hC0E4; s = 1'b1;
    step(); s = 1'b0; instr = 16'hFFFF;
    chk("movr_decode", NONE);
    step(); chk("movr_get_b", ex(0, 0, 0, 2'b00, 4, 0, 1, 0, 0, 0, 0));
    step(); chk("movr_alu",   ex(0, 0, 0, 2'b00, 0, 0, 0, 1, 1, 1, 0));
    step(); chk("movr_write", ex(0, 1, 7, 2'b00, 0, 0, 0, 0, 0, 0, 0));
    step(); chk("movr_done", IDLE);

    // s held high: ignored mid-instruction, restarts straight from WAIT
    instr = 16'hD32A; s = 1'b1;
    step(); chk("b2b_decode", NONE);
    step(); chk("b2b_write", ex(0, 1, 3, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    step(); chk("b2b_wait", IDLE);
    step(); s = 1'b0;
    chk("b2b_decode2", NONE);
    step(); chk("b2b_write2", ex(0, 1, 3, 2'b10, 0, 0, 0, 0, 0, 0, 0));
    step(); chk("b2b_done", IDLE);

    // illegal encoding
    instr = 16'hE000; s = 1'b1;
    step(); s = 1'b0;
    chk("ill_decode", ex(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1));
    step(); chk("ill_done", IDLE);

    // reset during GET_B of an ADD
    instr = 16'hA140; s = 1'b1;
    step(); s = 1'b0;
    step(); chk("rst_add_get_a", ex(0, 0, 0, 2'b00, 1, 1, 0, 0, 0, 0, 0));
    step(); chk("rst_add_get_b", ex(0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_async", IDLE);
    step(); chk("rst_mid_held", IDLE);
    rst_n = 1'b1;
    step(); chk("rst_mid_after0", IDLE);
    step(); chk("rst_mid_after1", IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
